iccm_fetch_unit: RTL and testbench
==================================

Name: iccm_fetch_unit

Overview:
Instruction-fetch initiator on the controller side of the ICCM controller. It issues word reads (cntlr_rd/cntlr_raddr) and consumes the one-cycle-later return (cntlr_rd_data/cntlr_rd_valid). Returned words are buffered in a small prefetch FIFO and presented to decode with a valid/ready handshake. Supports pipeline redirect (branch/trap) and replays reads the controller drops because a write took priority.

Parameters:
ADDR_WIDTH, 11, ICCM word-address width (2048 words)
DATA_WIDTH, 32, instruction word width
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
RESET_PC, 0, word address fetched first after reset

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
fetch_en  in  1  allow new read issue
redirect_valid  in  1  flush and restart fetch
redirect_addr  in  ADDR_WIDTH  new word address
cntlr_rd  out  1  read request to ICCM controller
cntlr_raddr  out  ADDR_WIDTH  read word address
cntlr_rd_data  in  DATA_WIDTH  read data, valid with cntlr_rd_valid
cntlr_rd_valid  in  1  read return, one cycle after accepted cntlr_rd
instr_valid  out  1  FIFO head valid
instr_data  out  DATA_WIDTH  FIFO head instruction
instr_pc  out  ADDR_WIDTH  word address of instr_data
instr_ready  in  1  decode accepts head

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, rst_n.
- Reset: cntlr_rd=0, cntlr_raddr=0, instr_valid=0, instr_data=0, instr_pc=0, FIFO empty, inflight=0, issue_pc=RESET_PC.
- State: issue_pc (next address), inflight flag plus inflight_addr (request from previous cycle), FIFO count/pointers. No other FSM.
- Return latency is exactly 1 cycle. If inflight=1, the current cycle is the response cycle.
- Drop: inflight=1 and cntlr_rd_valid=0 means the controller served a write instead. issue_pc <= inflight_addr. No issue this cycle.
- Push: inflight=1, cntlr_rd_valid=1 and redirect_valid=0. Push {cntlr_rd_data, inflight_addr}.
- Issue, combinational from registered state and same-cycle inputs: cntlr_rd = fetch_en & !redirect_valid & !drop & (count + inflight < DEPTH). cntlr_raddr = issue_pc when issuing, else 0.
- On issue: inflight<=1, inflight_addr<=issue_pc, issue_pc<=issue_pc+1, modulo 2^ADDR_WIDTH (0x7FF wraps to 0x000).
- The issue limit counts the in-flight read, so a push never overflows. Push and pop in the same cycle are legal at any count, full included.
- Pop when instr_valid & instr_ready. instr_valid = !empty & !redirect_valid. instr_data/instr_pc are the FIFO head, held stable while valid & !ready.
- Redirect (highest priority):
  - FIFO cleared next cycle.
  - Any response arriving in the redirect cycle is discarded.
  - No issue, no pop.
  - issue_pc <= redirect_addr, inflight <= 0.
  - The first read of redirect_addr is issued the following cycle, if fetch_en is set.
- fetch_en=0: no new issue. An in-flight response is still pushed or replayed.
- Asynchronous reset mid-operation returns all state to reset values immediately. Responses arriving after reset deasserts are ignored because inflight=0.
- Ordering: instructions leave strictly in address order between redirects, with no gaps or duplicates, including across drops.

Decomposition:
- iccm_pkg: ICCM_ADDR_WIDTH=11, ICCM_DATA_WIDTH=32, and a fetch-entry struct {data, pc} shared with decode.
- Sub-module iccm_fetch_fifo: synchronous FIFO with DEPTH entries, push/pop/flush, count, head outputs.
- Top level contains only the issue/replay/redirect logic.

Test Plan:
- Reset release, RESET_PC=0x010, fetch_en=1, instr_ready=1, memory model word=0xA000_0000+addr -> cntlr_rd=1/cntlr_raddr=0x010 in cycle 0; instr_valid=1, instr_pc=0x010, instr_data=0xA000_0010 in cycle 2; then one instruction per cycle.
- instr_ready=0, DEPTH=4 -> exactly 4 reads issued (0x010..0x013), then cntlr_rd=0 with count=4. Raising instr_ready resumes issue at 0x014 with no loss.
- Memory model drops the read of 0x012 (cntlr_rd_valid=0) -> next issued address is 0x012. Output sequence is 0x010,0x011,0x012,0x013, no duplicates.
- redirect_valid=1, redirect_addr=0x200 while 3 entries are buffered and 0x015 is in flight -> 0x015 response discarded, instr_valid=0 in the redirect cycle and the next, next cntlr_raddr=0x200, first output instr_pc=0x200.
- RESET_PC=0x7FE -> issued addresses 0x7FE, 0x7FF, 0x000, 0x001; instr_pc follows the same wrap.
- rst_n pulsed low asynchronously with a read in flight and the FIFO half full -> outputs reach reset values without waiting for a clock edge. After release, fetch restarts at RESET_PC and the stale response is not pushed.

Source files
------------

// File: rtl/iccm_pkg.sv
// Shared ICCM fetch types: default widths and the {data, pc} entry handed to decode.
package iccm_pkg;

  localparam int ICCM_ADDR_WIDTH = 11;
  localparam int ICCM_DATA_WIDTH = 32;

  typedef struct packed {
    logic [ICCM_DATA_WIDTH-1:0] data;
    logic [ICCM_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/iccm_fetch_if.sv
// Fetch-unit bus: read port toward the ICCM controller plus the decode handshake.
interface iccm_fetch_if
  import iccm_pkg::*;
#(
  parameter int ADDR_WIDTH = ICCM_ADDR_WIDTH,
  parameter int DATA_WIDTH = ICCM_DATA_WIDTH
) ();

  logic                  cntlr_rd;
  logic [ADDR_WIDTH-1:0] cntlr_raddr;
  logic [DATA_WIDTH-1:0] cntlr_rd_data;
  logic                  cntlr_rd_valid;
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr_data;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_ready;

  modport master (
    output cntlr_rd, cntlr_raddr,
    input  cntlr_rd_data, cntlr_rd_valid,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  cntlr_rd, cntlr_raddr,
    output cntlr_rd_data, cntlr_rd_valid,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/iccm_fetch_fifo.sv
// Prefetch FIFO: DEPTH entries, flush wins over push/pop, head is the oldest entry.
module iccm_fetch_fifo
  import iccm_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = 4,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        wdata,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage is reset too so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/iccm_fetch_unit.sv
// ICCM instruction fetch: issues word reads, replays dropped ones, buffers returns for decode.
module iccm_fetch_unit
  import iccm_pkg::*;
#(
  parameter int          ADDR_WIDTH = ICCM_ADDR_WIDTH,
  parameter int          DATA_WIDTH = ICCM_DATA_WIDTH,
  parameter int          DEPTH      = 4,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  iccm_fetch_if.master          bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  logic [ADDR_WIDTH-1:0] issue_pc_q, issue_pc_d;
  logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;
  logic                  inflight_q, inflight_d;

  logic          drop, push, pop, issue, instr_valid, empty;
  logic [CW:0]   occupancy;
  logic [CW-1:0] count;
  entry_t        head, wdata;

  always_comb begin
    // A missing return in the response cycle means a write won arbitration.
    drop        = inflight_q & ~bus.cntlr_rd_valid;
    push        = inflight_q & bus.cntlr_rd_valid & ~redirect_valid;
    occupancy   = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    // rst_n term keeps the request low while reset is held.
    issue       = rst_n & fetch_en & ~redirect_valid & ~drop &
                  (occupancy < (CW+1)'(DEPTH));
    instr_valid = ~empty & ~redirect_valid;
    pop         = instr_valid & bus.instr_ready;
    wdata       = '{data: bus.cntlr_rd_data, pc: inflight_addr_q};

    issue_pc_d      = issue_pc_q;
    inflight_addr_d = inflight_addr_q;
    inflight_d      = 1'b0;
    if (redirect_valid) begin
      issue_pc_d = redirect_addr;
    end else if (drop) begin
      issue_pc_d = inflight_addr_q;
    end else if (issue) begin
      inflight_d      = 1'b1;
      inflight_addr_d = issue_pc_q;
      issue_pc_d      = issue_pc_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_pc_q      <= ADDR_WIDTH'(RESET_PC);
      inflight_addr_q <= '0;
      inflight_q      <= 1'b0;
    end else begin
      issue_pc_q      <= issue_pc_d;
      inflight_addr_q <= inflight_addr_d;
      inflight_q      <= inflight_d;
    end
  end

  iccm_fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wdata),
    .head  (head),
    .count (count),
    .empty (empty)
  );

  assign bus.cntlr_rd    = issue;
  assign bus.cntlr_raddr = issue ? issue_pc_q : '0;
  assign bus.instr_valid = instr_valid;
  assign bus.instr_data  = head.data;
  assign bus.instr_pc    = head.pc;

endmodule

// File: tb/tb_iccm_fetch_unit.sv
// Scoreboarded bench for iccm_fetch_unit: random ICCM drops, back-pressure, redirects and resets.
module tb_iccm_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [10:0] redirect_addr = '0;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int replays = 0;

  logic [10:0] exp_q[$];
  logic [10:0] wi_q[$];
  logic [10:0] wp_q[$];

  iccm_fetch_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) f ();
  iccm_fetch_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) w ();

  iccm_fetch_unit #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC('h010)) u_dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .bus(f.master));

  iccm_fetch_unit #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC('h7FE)) u_wrap (
    .clk(clk), .rst_n(rst_n), .fetch_en(1'b1), .redirect_valid(1'b0),
    .redirect_addr(11'd0), .bus(w.master));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [10:0] a);
    return 32'hA000_0000 + {21'd0, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: after reset/redirect, decode sees consecutive addresses from the start point.
  task automatic push_seg(input logic [10:0] base);
    logic [10:0] a;
    exp_q.delete();
    a = base;
    for (int i = 0; i < 128; i++) begin
      exp_q.push_back(a);
      a = a + 11'd1;
    end
  endtask

  // ICCM model: one-cycle return, optional one-shot drop of drop_addr and random drops.
  int          rnd = 0;
  int          drop_pct = 0;
  int          drop_tok = 0;
  int          drop_used = 0;
  logic [10:0] drop_addr = '0;
  logic        drop_sel;

  always_comb
    drop_sel = f.cntlr_rd && ((f.cntlr_raddr == drop_addr && drop_tok != drop_used) ||
                              (rnd < drop_pct));

  always @(posedge clk) begin
    rnd              <= $urandom_range(99);
    f.cntlr_rd_valid <= f.cntlr_rd && !drop_sel;
    f.cntlr_rd_data  <= mem_word(f.cntlr_raddr);
    if (f.cntlr_rd && f.cntlr_raddr == drop_addr && drop_tok != drop_used) drop_used <= drop_tok;
    w.cntlr_rd_valid <= w.cntlr_rd;
    w.cntlr_rd_data  <= mem_word(w.cntlr_raddr);
  end

  // Monitor: pops expectations on every accepted instruction, checks replay and hold rules.
  logic        prev_v, prev_r, req_seen, rchk;
  logic [10:0] prev_pc, req_addr, rexp, e;
  logic [31:0] prev_data;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_v = 1'b0; req_seen = 1'b0; rchk = 1'b0;
      wi_q.delete(); wp_q.delete();
    end else begin
      if (redirect_valid) chk("redirect_valid_gate", {31'd0, f.instr_valid}, 32'd0);
      if (!f.cntlr_rd) chk("idle_raddr_zero", {21'd0, f.cntlr_raddr}, 32'd0);
      if (prev_v && !prev_r && f.instr_valid) begin
        chk("hold_pc", {21'd0, f.instr_pc}, {21'd0, prev_pc});
        chk("hold_data", f.instr_data, prev_data);
      end
      if (f.instr_valid && f.instr_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_underflow actual_pc=%h expected=none t=%0t", f.instr_pc, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", {21'd0, f.instr_pc}, {21'd0, e});
          chk("out_data", f.instr_data, mem_word(e));
        end
      end
      if (redirect_valid) rchk = 1'b0;
      else if (req_seen && !f.cntlr_rd_valid) begin
        rchk = 1'b1; rexp = req_addr;
      end else if (rchk && f.cntlr_rd) begin
        rchk = 1'b0; replays++;
        chk("replay_addr", {21'd0, f.cntlr_raddr}, {21'd0, rexp});
      end
      req_seen  = f.cntlr_rd;
      req_addr  = f.cntlr_raddr;
      prev_v    = f.instr_valid;
      prev_r    = f.instr_ready;
      prev_pc   = f.instr_pc;
      prev_data = f.instr_data;
      if (w.cntlr_rd && wi_q.size() < 4) wi_q.push_back(w.cntlr_raddr);
      if (w.instr_valid && wp_q.size() < 4) wp_q.push_back(w.instr_pc);
    end
  end

  task automatic do_reset(input bit fe, input bit rdy);
    @(posedge clk); #1;
    rst_n = 1'b0; fetch_en = fe; f.instr_ready = rdy; redirect_valid = 1'b0;
    push_seg(11'h010);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n, p0, r0, since;
    bit got;
    logic [10:0] wexp;

    // Reset state and first-fetch latency
    fetch_en = 1'b1; f.instr_ready = 1'b1; w.instr_ready = 1'b1;
    #12;
    chk("rst_cntlr_rd", {31'd0, f.cntlr_rd}, 32'd0);
    chk("rst_raddr", {21'd0, f.cntlr_raddr}, 32'd0);
    chk("rst_instr_valid", {31'd0, f.instr_valid}, 32'd0);
    chk("rst_instr_pc", {21'd0, f.instr_pc}, 32'd0);
    chk("rst_instr_data", f.instr_data, 32'd0);
    push_seg(11'h010);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("c0_cntlr_rd", {31'd0, f.cntlr_rd}, 32'd1);
    chk("c0_raddr", {21'd0, f.cntlr_raddr}, 32'h010);
    @(negedge clk); @(negedge clk);
    chk("c2_instr_valid", {31'd0, f.instr_valid}, 32'd1);
    chk("c2_instr_pc", {21'd0, f.instr_pc}, 32'h010);
    chk("c2_instr_data", f.instr_data, 32'hA000_0010);
    @(posedge clk); #1; p0 = pops;
    repeat (8) @(posedge clk);
    #1; chk("one_per_cycle", pops - p0, 32'd8);
    wexp = 11'h7FE;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_issue", (wi_q.size() > i) ? {21'd0, wi_q[i]} : 32'hFFFF_FFFF, {21'd0, wexp});
      chk("wrap_pc", (wp_q.size() > i) ? {21'd0, wp_q[i]} : 32'hFFFF_FFFF, {21'd0, wexp});
      wexp = wexp + 11'd1;
    end

    // Back-pressure: exactly DEPTH reads, then resume at 0x014
    do_reset(1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n += int'(f.cntlr_rd);
    end
    chk("bp_issue_cnt", n, 32'd4);
    chk("bp_stalled", {31'd0, f.cntlr_rd}, 32'd0);
    @(posedge clk); #1; f.instr_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (f.cntlr_rd) got = 1'b1;
    end
    chk("bp_resume_addr", got ? {21'd0, f.cntlr_raddr} : 32'hFFFF_FFFF, 32'h014);
    repeat (20) @(posedge clk);

    // Drop of 0x012 must be replayed in order
    drop_addr = 11'h012; drop_tok++;
    r0 = replays;
    do_reset(1'b1, 1'b1);
    repeat (20) @(posedge clk);
    chk("drop_replayed", replays - r0, 32'd1);

    // Redirect with entries buffered and a read in flight
    do_reset(1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1; redirect_valid = 1'b1; redirect_addr = 11'h200; push_seg(11'h200);
    @(negedge clk);
    chk("redir_valid_low", {31'd0, f.instr_valid}, 32'd0);
    chk("redir_no_issue", {31'd0, f.cntlr_rd}, 32'd0);
    @(posedge clk); #1; redirect_valid = 1'b0; f.instr_ready = 1'b1;
    @(negedge clk);
    chk("post_redir_valid_low", {31'd0, f.instr_valid}, 32'd0);
    chk("post_redir_rd", {31'd0, f.cntlr_rd}, 32'd1);
    chk("post_redir_raddr", {21'd0, f.cntlr_raddr}, 32'h200);
    p0 = pops;
    repeat (15) @(posedge clk);
    #1; chk("redir_progress", (pops - p0 > 5) ? 32'd1 : 32'd0, 32'd1);

    // Asynchronous reset mid-fetch; stale return must be ignored
    do_reset(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b0; push_seg(11'h010);
    #1;
    chk("arst_cntlr_rd", {31'd0, f.cntlr_rd}, 32'd0);
    chk("arst_raddr", {21'd0, f.cntlr_raddr}, 32'd0);
    chk("arst_instr_valid", {31'd0, f.instr_valid}, 32'd0);
    chk("arst_instr_pc", {21'd0, f.instr_pc}, 32'd0);
    chk("arst_instr_data", f.instr_data, 32'd0);
    #1; rst_n = 1'b1;
    @(negedge clk);
    chk("arst_restart_raddr", {21'd0, f.cntlr_raddr}, 32'h010);
    @(posedge clk); #1; f.instr_ready = 1'b1;
    repeat (15) @(posedge clk);

    // Random traffic with drops, stalls and redirects
    drop_pct = 20; p0 = pops; since = 0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      fetch_en      = ($urandom_range(99) < 90);
      f.instr_ready = ($urandom_range(99) < 70);
      if (since >= 100 || $urandom_range(99) < 3) begin
        redirect_valid = 1'b1;
        redirect_addr  = ($urandom_range(3) == 0) ? 11'h7FC + 11'($urandom_range(3))
                                                  : 11'($urandom_range(2047));
        push_seg(redirect_addr);
        since = 0;
      end else begin
        redirect_valid = 1'b0;
        since++;
      end
    end
    @(posedge clk); #1; redirect_valid = 1'b0; drop_pct = 0;
    repeat (5) @(posedge clk);
    chk("random_progress", (pops - p0 > 300) ? 32'd1 : 32'd0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
